cache_rw_mem_responder: RTL and testbench
=========================================

Name: cache_rw_mem_responder

Overview:
Responder for the cache_rw_axi block-transfer interface. It is the memory-side end of the link that cache_top drives.
- Accepts one line-read or line-write request at a time.
- Models a backing memory of DEPTH 64-byte lines, with a configurable access latency and one 64-bit beat per cycle.
- Returns a one-cycle ready pulse with the 512-bit line.
- Used in place of the AXI master plus SoC memory for cache-level simulation and regression.

Parameters:
- BASE, 64'h8000_0000: byte address of line 0.
- DEPTH, 1024: number of 64-byte lines held (power of two).
- LATENCY, 4: wait cycles between acceptance and the first beat. 0 is legal.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- i_cache_rw_axi_valid, input, 1: request valid. The initiator holds it until it sees ready.
- i_cache_rw_axi_op, input, 1: 0 = read, 1 = write.
- i_cache_rw_axi_wdata, input, 512: write line. Beat i is bits [64i+63:64i].
- i_cache_rw_axi_addr, input, 64: byte address. Bits [5:0] are ignored (aligned down).
- i_cache_rw_axi_size, input, 2: beat size code. Only 3 (8 bytes) is supported.
- i_cache_rw_axi_blks, input, 8: beat count minus 1.
- o_cache_rw_axi_ready, output, 1: one-cycle completion pulse.
- o_cache_rw_axi_rdata, output, 512: read line, valid while ready=1 and held afterwards.
- o_busy, output, 1: high in every state except IDLE.
- o_err, output, 1: pulses with ready when the request was rejected.

Behaviour:
- Reset values: ready=0, rdata=0, err=0, busy=0, state=IDLE, beat counter=0, latency counter=0.
- Memory storage:
  - Array of DEPTH*8 64-bit words, zero at time 0.
  - Not cleared by rst.
- Request latch:
  - In IDLE, valid=1 at a clock edge latches op, addr, size, blks and wdata. The state moves to WAIT, or to BEAT if LATENCY=0.
  - Input changes after the latch are ignored until the next acceptance.
- Beat count and addressing:
  - nbeats = min(blks+1, 8).
  - line = (addr - BASE) >> 6.
- Error condition, evaluated at latch:
  - err_req = (size != 3), or addr < BASE, or addr >= BASE + DEPTH*64.
  - An erroring request still runs the full WAIT/BEAT timing.
  - It performs no memory write and returns rdata=0.
  - err=1 in the RESP cycle.
- States:
  - IDLE: waits for valid.
  - WAIT: counts LATENCY cycles, then goes to BEAT.
  - BEAT: one beat per cycle for beat index k = 0..nbeats-1.
    - Read: rdata[64k+:64] <= mem[line*8+k].
    - Write: mem[line*8+k] <= wdata_latched[64k+:64].
    - After the last beat, go to RESP.
  - RESP: ready=1 (err as computed) for exactly one cycle, then go to DONE.
  - DONE: one guard cycle in which valid is ignored, then go to IDLE.
- Read-data clearing:
  - On entry to BEAT for a read, rdata lanes with k >= nbeats are cleared to 0.
  - rdata is unchanged by writes.
- Latency: with valid sampled at edge A, ready is high during the cycle after edge A+1+LATENCY+nbeats. With LATENCY=4 and blks=7 that is 13 edges after acceptance.
- Guard cycle: the DONE state prevents re-acceptance of a valid that the initiator drops one cycle late. A valid still high in the cycle after DONE starts a new request.
- Write ordering: a read following a write to the same line returns the new data, because writes complete before RESP.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE with all outputs at reset values.
  - Write beats already committed remain in memory.
  - No ready pulse is issued for the aborted request.
- Simultaneous events: valid rising in the same cycle as rst is ignored, since rst has priority.

Test Plan:
- Line write then read: write at 0x8000_0000 with wdata words 0x8c2078a7_07e5484d..0x196df530_aeb93dad, blks=7, size=3, then read the same address.
  - Both requests: ready exactly 13 cycles after acceptance.
  - Read rdata equals the written line; err=0.
- Latency sweep: LATENCY=0 and LATENCY=10, read with blks=7.
  - Ready at 9 and 19 cycles after acceptance respectively.
  - busy high from the cycle after acceptance through DONE.
- Partial burst: read with blks=1 at 0x8000_0040 after a full-line write there.
  - rdata[127:0] equals the written words 0 and 1; rdata[511:128]=0.
  - Ready 7 cycles after acceptance.
- Errors: read at 0x7FFF_FFC0; write at BASE+DEPTH*64; read with size=2.
  - Each: ready with err=1 and rdata=0.
  - Memory unchanged, checked by a following valid read.
- Held valid: initiator keeps valid high one cycle past ready.
  - No second ready; the responder returns to IDLE without accepting.
  - Valid held two cycles past ready starts a new request.
- Reset mid-burst: assert rst during beat 4 of a write of all-ones to line 0, which previously held all zeros.
  - ready and busy drop to 0 next cycle with no ready pulse.
  - A subsequent read returns words 0-3 = all ones and words 4-7 = 0.

Source files
------------

// File: rtl/cache_rw_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_rw_mem_responder_if
// Purpose  : Block-transfer request/response bundle between a cache-side
//            initiator (cache_top) and a memory-side responder.
// Signals  : i_cache_rw_axi_valid  request valid, held until ready
//            i_cache_rw_axi_op     0 = line read, 1 = line write
//            i_cache_rw_axi_wdata  512-bit write line, beat i = [64i+63:64i]
//            i_cache_rw_axi_addr   byte address, bits [5:0] ignored
//            i_cache_rw_axi_size   beat size code (3 = 8 bytes)
//            i_cache_rw_axi_blks   beat count minus one
//            o_cache_rw_axi_ready  one-cycle completion pulse
//            o_cache_rw_axi_rdata  512-bit read line, held after ready
// Modports : master (initiator side), slave (responder side)
// Revision : 1.0 - initial release
// ============================================================================
interface cache_rw_mem_responder_if;
  logic         i_cache_rw_axi_valid;
  logic         i_cache_rw_axi_op;
  logic [511:0] i_cache_rw_axi_wdata;
  logic [63:0]  i_cache_rw_axi_addr;
  logic [1:0]   i_cache_rw_axi_size;
  logic [7:0]   i_cache_rw_axi_blks;
  logic         o_cache_rw_axi_ready;
  logic [511:0] o_cache_rw_axi_rdata;

  modport master (
    output i_cache_rw_axi_valid,
    output i_cache_rw_axi_op,
    output i_cache_rw_axi_wdata,
    output i_cache_rw_axi_addr,
    output i_cache_rw_axi_size,
    output i_cache_rw_axi_blks,
    input  o_cache_rw_axi_ready,
    input  o_cache_rw_axi_rdata
  );

  modport slave (
    input  i_cache_rw_axi_valid,
    input  i_cache_rw_axi_op,
    input  i_cache_rw_axi_wdata,
    input  i_cache_rw_axi_addr,
    input  i_cache_rw_axi_size,
    input  i_cache_rw_axi_blks,
    output o_cache_rw_axi_ready,
    output o_cache_rw_axi_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_rw_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_rw_mem_responder
// Purpose  : Memory-side responder for the cache_rw_axi block-transfer link.
//            Holds DEPTH 64-byte lines, accepts one line read or write at a
//            time, waits LATENCY cycles, moves one 64-bit beat per cycle and
//            returns a one-cycle ready pulse with the 512-bit line.
// Ports    : clk     clock
//            rst     synchronous active-high reset
//            rw      cache_rw_mem_responder_if.slave request/response bundle
//            o_busy  high in every state except IDLE
//            o_err   pulses with ready when the request was rejected
// Params   : BASE    byte address of line 0 (64-byte aligned)
//            DEPTH   number of lines (power of two, >= 2)
//            LATENCY wait cycles between acceptance and first beat (0 legal)
// Revision : 1.0 - initial release
// ============================================================================
module cache_rw_mem_responder #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_rw_mem_responder_if.slave rw,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int unsigned      LINE_W   = $clog2(DEPTH);
  localparam int unsigned      LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
  localparam logic [63:0]      LIMIT    = BASE + 64'(DEPTH) * 64'd64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_BEAT = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Backing store: DEPTH lines of eight 64-bit words. Not touched by rst.
  logic [63:0] mem_q [DEPTH*8];

  state_t              state_q;
  logic                ready_q;
  logic                err_q;
  logic                busy_q;
  logic [511:0]        rdata_q;
  logic [3:0]          beat_q;
  logic [LAT_W-1:0]    lat_q;

  // Request captured at acceptance
  logic                op_q;
  logic [511:0]        wdata_q;
  logic [LINE_W-1:0]   line_q;
  logic [3:0]          nbeats_q;
  logic                req_err_q;

  // Decode of the request currently on the bus
  logic [LINE_W-1:0]   line_d;
  logic [3:0]          nbeats_d;
  logic                req_err_d;

  logic [LINE_W+2:0]   mem_idx;
  logic                mem_we;

  // BASE and LIMIT are line aligned, so comparing and subtracting the raw
  // address gives the same result as using the address aligned down.
  always_comb begin
    line_d    = LINE_W'((rw.i_cache_rw_axi_addr - BASE) >> 6);
    nbeats_d  = (rw.i_cache_rw_axi_blks >= 8'd7) ? 4'd8
                                                 : ({1'b0, rw.i_cache_rw_axi_blks[2:0]} + 4'd1);
    req_err_d = (rw.i_cache_rw_axi_size != 2'd3) ||
                (rw.i_cache_rw_axi_addr < BASE)   ||
                (rw.i_cache_rw_axi_addr >= LIMIT);
  end

  // Lanes of rdata that survive entry to BEAT: a rejected request clears the
  // whole line, a read clears the lanes it will not fill, a write keeps all.
  function automatic logic [511:0] lane_keep(input logic       is_write,
                                             input logic [3:0] n,
                                             input logic       is_err);
    logic [511:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if (!is_err && (is_write || (4'(k) < n))) begin
        m[64*k +: 64] = '1;
      end
    end
    return m;
  endfunction

  assign mem_idx = {line_q, beat_q[2:0]};
  assign mem_we  = !rst && (state_q == S_BEAT) && (beat_q != nbeats_q) &&
                   op_q && !req_err_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= wdata_q[{beat_q[2:0], 6'd0} +: 64];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      op_q      <= 1'b0;
      wdata_q   <= '0;
      line_q    <= '0;
      nbeats_q  <= '0;
      req_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rw.i_cache_rw_axi_valid) begin
            op_q      <= rw.i_cache_rw_axi_op;
            wdata_q   <= rw.i_cache_rw_axi_wdata;
            line_q    <= line_d;
            nbeats_q  <= nbeats_d;
            req_err_q <= req_err_d;
            beat_q    <= '0;
            lat_q     <= '0;
            busy_q    <= 1'b1;
            if (LATENCY == 0) begin
              state_q <= S_BEAT;
              rdata_q <= rdata_q & lane_keep(rw.i_cache_rw_axi_op, nbeats_d, req_err_d);
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q <= S_BEAT;
            rdata_q <= rdata_q & lane_keep(op_q, nbeats_q, req_err_q);
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end

        // One beat per edge while beat_q < nbeats_q; the edge after the last
        // beat raises ready, so write data is in memory before the pulse.
        S_BEAT: begin
          if (beat_q == nbeats_q) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= req_err_q;
          end else begin
            if (!op_q && !req_err_q) begin
              rdata_q[{beat_q[2:0], 6'd0} +: 64] <= mem_q[mem_idx];
            end
            beat_q <= beat_q + 4'd1;
          end
        end

        S_RESP: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_DONE;
        end

        // Guard cycle: a valid the initiator drops one cycle late is ignored.
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rw.o_cache_rw_axi_ready = ready_q;
  assign rw.o_cache_rw_axi_rdata = rdata_q;
  assign o_busy                  = busy_q;
  assign o_err                   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_rw_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_rw_mem_responder
// Purpose  : Self-checking bench for cache_rw_mem_responder. Three responders
//            (LATENCY 4, 0 and 10) share clk/rst; a line-level memory model
//            predicts rdata, err and ready timing for every request.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_rw_mem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd64;
  localparam int          NDUT  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0] valid;
  logic [NDUT-1:0] op;
  logic [511:0]    wdata [NDUT];
  logic [63:0]     addr  [NDUT];
  logic [1:0]      size  [NDUT];
  logic [7:0]      blks  [NDUT];
  logic [NDUT-1:0] ready;
  logic [NDUT-1:0] err;
  logic [NDUT-1:0] busy;
  logic [511:0]    rdata [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cache_rw_mem_responder_if u_if ();
    assign u_if.i_cache_rw_axi_valid = valid[g];
    assign u_if.i_cache_rw_axi_op    = op[g];
    assign u_if.i_cache_rw_axi_wdata = wdata[g];
    assign u_if.i_cache_rw_axi_addr  = addr[g];
    assign u_if.i_cache_rw_axi_size  = size[g];
    assign u_if.i_cache_rw_axi_blks  = blks[g];
    assign ready[g]                  = u_if.o_cache_rw_axi_ready;
    assign rdata[g]                  = u_if.o_cache_rw_axi_rdata;

    cache_rw_mem_responder #(
      .BASE    (BASE),
      .DEPTH   (DEPTH),
      .LATENCY ((g == 0) ? 4 : ((g == 1) ? 0 : 10))
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .rw     (u_if),
      .o_busy (busy[g]),
      .o_err  (err[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int lat_of [NDUT] = '{4, 0, 10};

  // Reference model: word-addressed memory per responder plus last rdata.
  logic [63:0]  model_mem [int];
  logic [511:0] model_rd  [NDUT];

  function automatic int mkey(input int d, input longint unsigned word);
    return d * 65536 + int'(word);
  endfunction

  function automatic logic [63:0] mem_get(input int d, input longint unsigned word);
    if (model_mem.exists(mkey(d, word))) return model_mem[mkey(d, word)];
    return 64'd0;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_req(input int d, input logic o, input logic [63:0] a,
                           input logic [1:0] sz, input logic [7:0] b,
                           input logic [511:0] wd, output logic [511:0] exp_rd,
                           output logic exp_err, output int exp_lat);
    int n;
    longint unsigned line;
    n       = (int'(b) + 1 > 8) ? 8 : int'(b) + 1;
    exp_err = (sz != 2'd3) || (a < BASE) || (a >= LIMIT);
    exp_lat = 1 + lat_of[d] + n;
    if (exp_err) begin
      model_rd[d] = '0;
    end else begin
      line = (a - BASE) / 64;
      if (o) begin
        for (int k = 0; k < n; k++) model_mem[mkey(d, line * 8 + k)] = wd[64*k +: 64];
      end else begin
        model_rd[d] = '0;
        for (int k = 0; k < n; k++) model_rd[d][64*k +: 64] = mem_get(d, line * 8 + k);
      end
    end
    exp_rd = model_rd[d];
  endtask

  task automatic scramble(input int d);
    op[d]    = 1'($urandom);
    addr[d]  = {$urandom, $urandom};
    size[d]  = 2'($urandom);
    blks[d]  = 8'($urandom);
    wdata[d] = rand512();
  endtask

  // Issues one request, scrambles the bus after acceptance, and checks
  // latency, rdata, err, busy, single-cycle pulse and return to idle.
  task automatic run_req(input int d, input logic o, input logic [63:0] a,
                         input logic [1:0] sz, input logic [7:0] b,
                         input logic [511:0] wd, input string nm);
    logic [511:0] erd, grd;
    logic         eerr, gerr;
    int           elat, got;
    bit           busy_bad;
    model_req(d, o, a, sz, b, wd, erd, eerr, elat);
    op[d] = o; addr[d] = a; size[d] = sz; blks[d] = b; wdata[d] = wd;
    valid[d] = 1'b1;
    @(posedge clk); #1;
    busy_bad = (busy[d] !== 1'b1);
    scramble(d);
    got = -1; grd = '0; gerr = 1'b0;
    for (int k = 1; k <= 48 && got < 0; k++) begin
      @(posedge clk); #1;
      if (busy[d] !== 1'b1) busy_bad = 1;
      if (ready[d] === 1'b1) begin
        got = k; grd = rdata[d]; gerr = err[d];
        valid[d] = 1'b0;
      end
    end
    valid[d] = 1'b0;
    checks++;
    if (got != elat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", nm, got, elat);
    end
    checks++;
    if (grd !== erd) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", nm, grd, erd);
    end
    checks++;
    if (gerr !== eerr) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", nm, gerr, eerr);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy: dropped before ready, expected 1 throughout", nm);
    end
    @(posedge clk); #1;
    checks++;
    if (ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s guard: ready=%b busy=%b expected ready=0 busy=1", nm, ready[d], busy[d]);
    end
    @(posedge clk); #1;
    checks++;
    if (busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b expected 0", nm, busy[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (ready[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0 || rdata[d] !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: ready=%b err=%b busy=%b rdata_nonzero=%b expected all 0",
                 d, ready[d], err[d], busy[d], |rdata[d]);
      end
      model_rd[d] = '0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [511:0] line;
    line = rand512();
    line[63:0]    = 64'h8c2078a7_07e5484d;
    line[511:448] = 64'h196df530_aeb93dad;
    run_req(0, 1'b1, BASE, 2'd3, 8'd7, line, "wr_line");
    run_req(0, 1'b0, BASE, 2'd3, 8'd7, '0, "rd_line");
  endtask

  task automatic test_latency_sweep();
    for (int d = 1; d < NDUT; d++) begin
      run_req(d, 1'b1, BASE + 64'd320, 2'd3, 8'd7, rand512(), $sformatf("lat%0d_wr", lat_of[d]));
      run_req(d, 1'b0, BASE + 64'd320, 2'd3, 8'd7, '0, $sformatf("lat%0d_rd", lat_of[d]));
    end
  endtask

  task automatic test_partial_burst();
    run_req(0, 1'b1, BASE + 64'h40, 2'd3, 8'd7, rand512(), "partial_wr");
    run_req(0, 1'b0, BASE + 64'h40, 2'd3, 8'd1, '0, "partial_rd");
  endtask

  task automatic test_errors();
    run_req(0, 1'b0, 64'h7FFF_FFC0, 2'd3, 8'd7, '0, "err_below");
    run_req(0, 1'b1, LIMIT, 2'd3, 8'd7, rand512(), "err_above_wr");
    run_req(0, 1'b0, BASE, 2'd2, 8'd7, '0, "err_size");
    run_req(0, 1'b0, BASE, 2'd3, 8'd7, '0, "err_readback");
  endtask

  // h=1: valid held through the cycle after ready, must not re-accept.
  // h=2: valid held one cycle longer, starts a new request.
  task automatic test_held_valid();
    logic [511:0] erd;
    logic         eerr;
    int           elat, got, pulses;
    bit           seen;
    for (int h = 1; h <= 2; h++) begin
      model_req(0, 1'b0, BASE + 64'd192, 2'd3, 8'd7, '0, erd, eerr, elat);
      op[0] = 1'b0; addr[0] = BASE + 64'd192; size[0] = 2'd3; blks[0] = 8'd7;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      got = -1;
      for (int k = 1; k <= 48 && got < 0; k++) begin
        @(posedge clk); #1;
        if (ready[0] === 1'b1) got = k;
      end
      checks++;
      if (got != elat || rdata[0] !== erd) begin
        errors++;
        $display("FAIL held%0d first: latency %0d expected %0d, rdata_ok=%b", h, got, elat, rdata[0] === erd);
      end
      pulses = 0;
      for (int j = 0; j <= h; j++) begin
        @(posedge clk); #1;
        if (ready[0] === 1'b1) pulses++;
      end
      valid[0] = 1'b0;
      checks++;
      if (pulses != 0) begin
        errors++;
        $display("FAIL held%0d extra_ready: got %0d pulses expected 0", h, pulses);
      end
      if (h == 1) begin
        seen = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (ready[0] !== 1'b0 || busy[0] !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
          errors++;
          $display("FAIL held1 reaccept: responder active=1 expected 0");
        end
      end else begin
        model_req(0, 1'b0, BASE + 64'd192, 2'd3, 8'd7, '0, erd, eerr, elat);
        got = -1;
        for (int k = 1; k <= 48 && got < 0; k++) begin
          @(posedge clk); #1;
          if (ready[0] === 1'b1) got = k;
        end
        checks++;
        if (got != elat || rdata[0] !== erd || err[0] !== eerr) begin
          errors++;
          $display("FAIL held2 second: latency %0d expected %0d, rdata_ok=%b err=%b",
                   got, elat, rdata[0] === erd, err[0]);
        end
        repeat (3) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit bad;
    run_req(0, 1'b1, BASE, 2'd3, 8'd7, '0, "rst_zero_fill");
    op[0] = 1'b1; addr[0] = BASE; size[0] = 2'd3; blks[0] = 8'd7;
    wdata[0] = {512{1'b1}};
    valid[0] = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    // WAIT takes 4 edges, then beats 0..3 commit on the next 4 edges.
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[0] !== 1'b0) bad = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready[0] !== 1'b0 || busy[0] !== 1'b0 || err[0] !== 1'b0 || rdata[0] !== '0) begin
      errors++;
      $display("FAIL rst_abort: ready=%b busy=%b err=%b rdata_nonzero=%b expected all 0",
               ready[0], busy[0], err[0], |rdata[0]);
    end
    rst = 1'b0;
    valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) model_mem[mkey(0, k)] = {64{1'b1}};
    for (int d = 0; d < NDUT; d++) model_rd[d] = '0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_no_pulse: spurious ready/busy=1 expected 0");
    end
    run_req(0, 1'b0, BASE, 2'd3, 8'd7, '0, "rst_readback");
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [1:0]  sz;
    int          sel;
    for (int l = 0; l < 8; l++)
      run_req(0, 1'b1, BASE + 64'(l) * 64, 2'd3, 8'd7, rand512(), $sformatf("rnd_init%0d", l));
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE - 64'd64 + 64'($urandom_range(0, 63));
      else if (sel == 1) a = LIMIT + 64'($urandom_range(0, 4095));
      else               a = BASE + 64'($urandom_range(0, 7)) * 64 + 64'($urandom_range(0, 63));
      sz = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'd3;
      run_req(0, 1'($urandom), a, sz, 8'($urandom_range(0, 12)), rand512(),
              $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      valid[d] = 1'b0; op[d] = 1'b0; wdata[d] = '0;
      addr[d] = '0; size[d] = 2'd3; blks[d] = '0;
    end
    test_reset();
    test_write_read();
    test_latency_sweep();
    test_partial_burst();
    test_errors();
    test_held_valid();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
